pattern_engine: RTL and testbench
=================================

Name: pattern_engine

Overview:
- Parametrised successor to the first-generation button/switch pattern generator.
- On a start press it loads an N-bit seed and steps it at a programmable rate. Each run stops after a programmable number of steps.
- Four step modes: rotate left, rotate right, Galois LFSR, rule-90 cellular automaton.
- Drives the pattern, step-instance and FSM-state displays in the top level.

Parameters:
- WIDTH, 8, pattern width in bits (>=4).
- CNT_W, 8, width of the instance counter.
- STEP_DIV, 4, clock cycles per step (>=1).
- MAX_STEPS, 5, steps per run (1..2^CNT_W-1).
- LFSR_TAPS, 8'hB8, Galois tap mask (WIDTH bits).

Ports:
- clk  in  1  system clock; only clock in the block.
- rst  in  1  synchronous, active-low reset.
- start  in  1  raw start button level, already synchronised upstream.
- mode_sel  in  2  step mode: 0 ROTL, 1 ROTR, 2 LFSR, 3 RULE90.
- seed  in  WIDTH  initial pattern.
- pattern  out  WIDTH  current pattern.
- inst_count  out  CNT_W  steps completed in the current run.
- actual_state  out  4  FSM state code.
- busy  out  1  high in LOAD, RUN and PAUSE.
- done  out  1  high in DONE.

Behaviour:
- Reset (rst==0 at a clk edge):
  - pattern=0, inst_count=0, actual_state=IDLE, busy=0, done=0.
  - Step timer=0, start_q=0.
  - Reset has priority over every other event, including mid-run.
- Start edge: start_q registers start. rise = start & ~start_q (combinational). A held button produces exactly one rise.
- State codes: IDLE=0, LOAD=1, RUN=2, PAUSE=3, DONE=4. Codes 5-15 are unused and return to IDLE on the next edge.
- IDLE -> LOAD on the edge where rise=1.
- LOAD lasts 1 cycle:
  - pattern<=seed; inst_count<=0; timer<=0; mode<=mode_sel (latched).
  - If the latched mode is LFSR and seed==0, pattern<=1 so the LFSR cannot lock up.
  - LOAD -> RUN.
- RUN, timer below STEP_DIV-1: timer increments.
- RUN, timer==STEP_DIV-1:
  - pattern<=step(pattern); inst_count++; timer<=0.
  - If the new inst_count==MAX_STEPS -> DONE, else stay in RUN.
- First step latency: the pattern updates on the STEP_DIV-th edge after entering RUN.
- Step functions:
  - ROTL: {p[W-2:0],p[W-1]}.
  - ROTR: {p[0],p[W-1:1]}.
  - LFSR: p[0] ? (p>>1)^LFSR_TAPS : p>>1.
  - RULE90: n[i]=p[i+1]^p[i-1], out-of-range bits read as 0.
- Mode and seed changes after LOAD are ignored until the next LOAD.
- DONE holds pattern and inst_count. A rise in DONE -> LOAD, which restarts the run with the current seed and mode_sel.
- inst_count never wraps: it saturates at MAX_STEPS by construction.
- rise during RUN is ignored unless PATTERN_PAUSE_EN is defined.

Optional Feature:
- Macro: PATTERN_PAUSE_EN.
- Defined:
  - A rise in RUN -> PAUSE; timer, pattern and inst_count freeze.
  - A rise in PAUSE -> RUN, resuming at the frozen timer value.
  - A rise on the same edge as a step completion: the step is applied first, then PAUSE (or DONE if MAX_STEPS is reached; DONE wins).
- Not defined: the PAUSE state is never entered, and rise in RUN has no effect.

Decomposition:
- Package pattern_pkg:
  - state_t enum, 4-bit, with the codes above.
  - mode_t enum, 2-bit.
  - Default LFSR_TAPS constant.
  - Pure step function step_pattern(mode, p), parametrised via the WIDTH passed in.
- Sub-module btn_edge_detect: start_q flop plus rise output, synchronous active-low reset. Reused by the top level for other buttons.

Test Plan (WIDTH=8, STEP_DIV=4, MAX_STEPS=5 unless stated):
- ROTL run: seed=0x81, mode=0, start pulse.
  - LOAD on the next edge; pattern=0x81.
  - pattern sequence 0x03, 0x06, 0x0C, 0x18, 0x30, one every 4 cycles.
  - inst_count=5, done=1, actual_state=4.
- LFSR run: seed=0x00, mode=2.
  - pattern=0x01 after LOAD.
  - Steps give 0xB8, 0x5C, 0x2E, 0x17, 0xB3.
  - ROTR sanity (seed=0x01, mode=1) gives 0x80 on step 1.
- RULE90 run: seed=0x08, mode=3.
  - Step 1 gives 0x14, step 2 gives 0x22.
  - Changing mode_sel to 0 mid-run does not alter the sequence.
- Held button: start held high for 40 cycles from IDLE.
  - Exactly one run occurs, and the block stays in DONE.
  - Release then press -> LOAD again, inst_count=0.
- Reset mid-run: rst=0 for one edge at inst_count=2.
  - All outputs return to reset values on that edge; state=IDLE.
  - The block stays in IDLE until a new rise.
- Pause (PATTERN_PAUSE_EN defined): press at inst_count=2, wait 20 cycles.
  - pattern, inst_count and timer stay frozen; state=3.
  - A second press resumes and completes the remaining 3 steps with the same timing as before the pause.

Source files
------------

// File: rtl/pattern_pkg.sv
// Shared types and the pure step function for the pattern engine.
// step_pattern works on a MAX_W-bit container; the caller passes its real width.
package pattern_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_LOAD  = 4'd1,
    ST_RUN   = 4'd2,
    ST_PAUSE = 4'd3,
    ST_DONE  = 4'd4
  } state_t;

  typedef enum logic [1:0] {
    MODE_ROTL   = 2'd0,
    MODE_ROTR   = 2'd1,
    MODE_LFSR   = 2'd2,
    MODE_RULE90 = 2'd3
  } mode_t;

  localparam int MAX_W = 64;
  localparam logic [7:0] DEFAULT_LFSR_TAPS = 8'hB8;

  typedef logic [MAX_W-1:0] wide_t;

  // Bits of p at or above w must be zero; the result keeps them zero.
  function automatic wide_t step_pattern(input mode_t mode, input wide_t p,
                                         input wide_t taps, input int w);
    wide_t mask;
    wide_t n;
    mask = (wide_t'(1) << w) - wide_t'(1);
    n    = p;
    unique case (mode)
      MODE_ROTL:   n = ((p << 1) | (p >> (w - 1))) & mask;
      MODE_ROTR:   n = (p >> 1) | (wide_t'(p[0]) << (w - 1));
      MODE_LFSR:   n = p[0] ? ((p >> 1) ^ taps) : (p >> 1);
      MODE_RULE90: n = ((p << 1) ^ (p >> 1)) & mask;
      default:     n = p;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// Registers a synchronised button level and flags its rising edge.
module btn_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  logic btn_q;
  logic btn_d;

  always_comb btn_d = btn;

  always_ff @(posedge clk) begin
    if (!rst) btn_q <= 1'b0;
    else      btn_q <= btn_d;
  end

  assign rise = btn & ~btn_q;

endmodule

// File: rtl/pattern_engine.sv
// Seeded pattern stepper (rotate / Galois LFSR / rule-90) with a fixed-length run.
// Define PATTERN_PAUSE_EN to let a start press pause and resume a run.
import pattern_pkg::*;

module pattern_engine #(
  parameter int              WIDTH     = 8,
  parameter int              CNT_W     = 8,
  parameter int              STEP_DIV  = 4,
  parameter int              MAX_STEPS = 5,
  parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(DEFAULT_LFSR_TAPS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode_sel,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] pattern,
  output logic [CNT_W-1:0] inst_count,
  output logic [3:0]       actual_state,
  output logic             busy,
  output logic             done
);

  localparam int TMR_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  state_t             state_q, state_d;
  mode_t              mode_q, mode_d;
  logic [WIDTH-1:0]   pattern_q, pattern_d;
  logic [CNT_W-1:0]   inst_count_q, inst_count_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               rise;
  logic               step_now;
  logic               last_step;
  logic [WIDTH-1:0]   stepped;

  btn_edge_detect u_start_edge (
    .clk  (clk),
    .rst  (rst),
    .btn  (start),
    .rise (rise)
  );

  assign step_now  = (timer_q == TMR_W'(STEP_DIV - 1));
  assign last_step = (inst_count_q == CNT_W'(MAX_STEPS - 1));
  assign stepped   = WIDTH'(step_pattern(mode_q, wide_t'(pattern_q),
                                         wide_t'(LFSR_TAPS), WIDTH));

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    pattern_d    = pattern_q;
    inst_count_d = inst_count_q;
    timer_d      = timer_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rise) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        mode_d       = mode_t'(mode_sel);
        inst_count_d = '0;
        timer_d      = '0;
        // An all-zero seed would freeze the LFSR forever.
        if ((mode_t'(mode_sel) == MODE_LFSR) && (seed == '0))
          pattern_d = WIDTH'(1);
        else
          pattern_d = seed;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (step_now) begin
          pattern_d    = stepped;
          inst_count_d = inst_count_q + CNT_W'(1);
          timer_d      = '0;
          if (last_step) state_d = ST_DONE;
`ifdef PATTERN_PAUSE_EN
          else if (rise) state_d = ST_PAUSE;
`endif
        end else begin
          timer_d = timer_q + TMR_W'(1);
`ifdef PATTERN_PAUSE_EN
          if (rise) begin
            timer_d = timer_q;
            state_d = ST_PAUSE;
          end
`endif
        end
      end
`ifdef PATTERN_PAUSE_EN
      ST_PAUSE: begin
        if (rise) state_d = ST_RUN;
      end
`endif
      ST_DONE: begin
        if (rise) state_d = ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_ROTL;
      pattern_q    <= '0;
      inst_count_q <= '0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      pattern_q    <= pattern_d;
      inst_count_q <= inst_count_d;
      timer_q      <= timer_d;
    end
  end

  assign pattern      = pattern_q;
  assign inst_count   = inst_count_q;
  assign actual_state = state_q;
  assign busy         = (state_q == ST_LOAD) || (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign done         = (state_q == ST_DONE);

endmodule

// File: tb/tb_pattern_engine.sv
// Directed bench for pattern_engine with default parameters (8-bit, 4 cycles/step, 5 steps).
module tb_pattern_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] mode_sel;
  logic [7:0] seed;
  logic [7:0] pattern;
  logic [7:0] inst_count;
  logic [3:0] actual_state;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  pattern_engine dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .mode_sel     (mode_sel),
    .seed         (seed),
    .pattern      (pattern),
    .inst_count   (inst_count),
    .actual_state (actual_state),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  // One-cycle start pulse; the edge it spans moves IDLE/DONE into LOAD.
  task automatic press();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; mode_sel = 2'd0; seed = 8'h00;
    tick();
    tick();
    checks++; if (pattern !== 8'h00) begin errors++; $display("FAIL reset_pattern got=%h exp=00", pattern); end
    checks++; if (inst_count !== 8'd0) begin errors++; $display("FAIL reset_inst got=%0d exp=0", inst_count); end
    checks++; if (actual_state !== 4'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", actual_state); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    rst = 1'b1;
    tick();
    checks++; if (actual_state !== 4'd0) begin errors++; $display("FAIL idle_no_press got=%0d exp=0", actual_state); end
  endtask

  task automatic test_rotl();
    logic [39:0] exp;
    logic [7:0]  prev;
    exp = {8'h30, 8'h18, 8'h0C, 8'h06, 8'h03};
    seed = 8'h81; mode_sel = 2'd0;
    press();
    checks++; if (actual_state !== 4'd1) begin errors++; $display("FAIL rotl_load_state got=%0d exp=1", actual_state); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rotl_load_busy got=%b exp=1", busy); end
    tick();
    checks++; if (pattern !== 8'h81) begin errors++; $display("FAIL rotl_seed got=%h exp=81", pattern); end
    checks++; if (actual_state !== 4'd2) begin errors++; $display("FAIL rotl_run_state got=%0d exp=2", actual_state); end
    prev = 8'h81;
    for (int k = 0; k < 5; k++) begin
      repeat (3) tick();
      checks++; if (pattern !== prev) begin errors++; $display("FAIL rotl_hold%0d got=%h exp=%h", k, pattern, prev); end
      tick();
      checks++; if (pattern !== exp[8*k +: 8]) begin errors++; $display("FAIL rotl_step%0d got=%h exp=%h", k + 1, pattern, exp[8*k +: 8]); end
      checks++; if (inst_count !== 8'(k + 1)) begin errors++; $display("FAIL rotl_inst%0d got=%0d exp=%0d", k + 1, inst_count, k + 1); end
      prev = exp[8*k +: 8];
    end
    checks++; if (actual_state !== 4'd4) begin errors++; $display("FAIL rotl_done_state got=%0d exp=4", actual_state); end
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rotl_flags got=done%b busy%b exp=done1 busy0", done, busy); end
    repeat (6) tick();
    checks++; if (pattern !== 8'h30 || inst_count !== 8'd5) begin errors++; $display("FAIL rotl_done_hold got=%h/%0d exp=30/5", pattern, inst_count); end
  endtask

  task automatic test_lfsr();
    logic [39:0] exp;
    exp = {8'hB3, 8'h17, 8'h2E, 8'h5C, 8'hB8};
    seed = 8'h00; mode_sel = 2'd2;
    press();
    tick();
    checks++; if (pattern !== 8'h01) begin errors++; $display("FAIL lfsr_zero_seed got=%h exp=01", pattern); end
    for (int k = 0; k < 5; k++) begin
      repeat (4) tick();
      checks++; if (pattern !== exp[8*k +: 8]) begin errors++; $display("FAIL lfsr_step%0d got=%h exp=%h", k + 1, pattern, exp[8*k +: 8]); end
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL lfsr_done got=%b exp=1", done); end
    seed = 8'h01; mode_sel = 2'd1;
    press();
    tick();
    checks++; if (pattern !== 8'h01 || inst_count !== 8'd0) begin errors++; $display("FAIL rotr_load got=%h/%0d exp=01/0", pattern, inst_count); end
    repeat (4) tick();
    checks++; if (pattern !== 8'h80) begin errors++; $display("FAIL rotr_step1 got=%h exp=80", pattern); end
    repeat (16) tick();
    checks++; if (actual_state !== 4'd4) begin errors++; $display("FAIL rotr_done got=%0d exp=4", actual_state); end
  endtask

  task automatic test_rule90();
    logic [39:0] exp;
    exp = {8'h40, 8'h80, 8'h55, 8'h22, 8'h14};
    seed = 8'h08; mode_sel = 2'd3;
    press();
    tick();
    for (int k = 0; k < 5; k++) begin
      repeat (4) tick();
      checks++; if (pattern !== exp[8*k +: 8]) begin errors++; $display("FAIL rule90_step%0d got=%h exp=%h", k + 1, pattern, exp[8*k +: 8]); end
      if (k == 0) begin
        mode_sel = 2'd0;
        seed     = 8'hFF;
      end
    end
    checks++; if (inst_count !== 8'd5 || done !== 1'b1) begin errors++; $display("FAIL rule90_end got=%0d/%b exp=5/1", inst_count, done); end
  endtask

  task automatic test_held_button();
    int loads;
    do_reset();
    seed = 8'h81; mode_sel = 2'd0;
    loads = 0;
    start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (actual_state == 4'd1) loads++;
    end
    checks++; if (loads !== 1) begin errors++; $display("FAIL held_loads got=%0d exp=1", loads); end
    checks++; if (actual_state !== 4'd4 || inst_count !== 8'd5) begin errors++; $display("FAIL held_done got=%0d/%0d exp=4/5", actual_state, inst_count); end
    checks++; if (pattern !== 8'h30) begin errors++; $display("FAIL held_pattern got=%h exp=30", pattern); end
    start = 1'b0;
    tick();
    seed = 8'h42;
    press();
    checks++; if (actual_state !== 4'd1) begin errors++; $display("FAIL held_repress got=%0d exp=1", actual_state); end
    tick();
    checks++; if (inst_count !== 8'd0 || pattern !== 8'h42) begin errors++; $display("FAIL held_reload got=%0d/%h exp=0/42", inst_count, pattern); end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    seed = 8'h81; mode_sel = 2'd0;
    press();
    tick();
    repeat (8) tick();
    checks++; if (inst_count !== 8'd2 || pattern !== 8'h06) begin errors++; $display("FAIL mid_pre got=%0d/%h exp=2/06", inst_count, pattern); end
    rst = 1'b0;
    tick();
    checks++; if (pattern !== 8'h00 || inst_count !== 8'd0) begin errors++; $display("FAIL mid_rst_data got=%h/%0d exp=00/0", pattern, inst_count); end
    checks++; if (actual_state !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mid_rst_ctrl got=%0d/%b/%b exp=0/0/0", actual_state, busy, done); end
    rst = 1'b1;
    repeat (10) tick();
    checks++; if (actual_state !== 4'd0 || pattern !== 8'h00) begin errors++; $display("FAIL mid_stay_idle got=%0d/%h exp=0/00", actual_state, pattern); end
    press();
    checks++; if (actual_state !== 4'd1) begin errors++; $display("FAIL mid_new_press got=%0d exp=1", actual_state); end
  endtask

  task automatic test_run_press_ignored();
    do_reset();
    seed = 8'h81; mode_sel = 2'd0;
    press();
    tick();
    repeat (9) tick();
`ifdef PATTERN_PAUSE_EN
    press();
    checks++; if (actual_state !== 4'd3) begin errors++; $display("FAIL pause_enter got=%0d exp=3", actual_state); end
    repeat (20) tick();
    checks++; if (actual_state !== 4'd3 || pattern !== 8'h06 || inst_count !== 8'd2) begin errors++; $display("FAIL pause_frozen got=%0d/%h/%0d exp=3/06/2", actual_state, pattern, inst_count); end
    press();
    checks++; if (actual_state !== 4'd2) begin errors++; $display("FAIL pause_resume got=%0d exp=2", actual_state); end
    repeat (2) tick();
    checks++; if (pattern !== 8'h06) begin errors++; $display("FAIL pause_early got=%h exp=06", pattern); end
    tick();
    checks++; if (pattern !== 8'h0C || inst_count !== 8'd3) begin errors++; $display("FAIL pause_step3 got=%h/%0d exp=0C/3", pattern, inst_count); end
    repeat (8) tick();
    checks++; if (pattern !== 8'h30 || done !== 1'b1) begin errors++; $display("FAIL pause_finish got=%h/%b exp=30/1", pattern, done); end
`else
    press();
    checks++; if (actual_state !== 4'd2) begin errors++; $display("FAIL nopause_state got=%0d exp=2", actual_state); end
    repeat (2) tick();
    checks++; if (pattern !== 8'h0C || inst_count !== 8'd3) begin errors++; $display("FAIL nopause_step3 got=%h/%0d exp=0C/3", pattern, inst_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_rotl();
    test_lfsr();
    test_rule90();
    test_held_button();
    test_reset_mid_run();
    test_run_press_ignored();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
